id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-delivery stage of the pipelined CPU, sitting directly upstream of the combinational ALU. It captures decoded instructions from ID and applies EX/MEM and MEM/WB forwarding. It drives the ALU operands `alu1`/`alu2` and the 4-bit `aluc`, detects load-use hazards and inserts bubbles, and honours downstream back-pressure and pipeline flush.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/fwd_mux.sv | 29 ++
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, ALU opcodes, operand-select encodings and decode helpers
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_REG_W  = 5;

    // ALU opcodes driven on aluc
    localparam logic [3:0] ALUC_ADD  = 4'b0000;
    localparam logic [3:0] ALUC_SUB  = 4'b0001;
    localparam logic [3:0] ALUC_AND  = 4'b0100;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0110;
    localparam logic [3:0] ALUC_NOR  = 4'b0111;
    localparam logic [3:0] ALUC_LUI  = 4'b1000;
    localparam logic [3:0] ALUC_SLT  = 4'b1010;
    localparam logic [3:0] ALUC_SLTU = 4'b1011;
    localparam logic [3:0] ALUC_SRA  = 4'b1100;
    localparam logic [3:0] ALUC_SRL  = 4'b1101;
    localparam logic [3:0] ALUC_SLL  = 4'b1110;

    // Operand-select encodings
    localparam logic SEL1_RS    = 1'b0;
    localparam logic SEL1_SHAMT = 1'b1;
    localparam logic SEL2_RT    = 1'b0;
    localparam logic SEL2_IMM   = 1'b1;

    // An instruction reads rs only when alu1 takes the register operand
    function automatic logic f_uses_rs(input logic alu1_sel);
        return alu1_sel == SEL1_RS;
    endfunction

    // Stores read rt as write data even when alu2 takes the immediate
    function automatic logic f_uses_rt(input logic alu2_sel, input logic mem_wr);
        return (alu2_sel == SEL2_RT) || mem_wr;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand bypass select: EX/MEM over MEM/WB over held register data
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [REG_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_held,
    input  logic              i_exm_en,
    input  logic [REG_W-1:0]  i_exm_addr,
    input  logic [DATA_W-1:0] i_exm_data,
    input  logic              i_mwb_en,
    input  logic [REG_W-1:0]  i_mwb_addr,
    input  logic [DATA_W-1:0] i_mwb_data,
    output logic [DATA_W-1:0] o_data
);

    // $0 is hardwired zero, so writes targeting it must never be bypassed
    always_comb begin
        o_data = i_held;
        if (i_addr != '0) begin
            if (i_exm_en && (i_exm_addr == i_addr)) begin
                o_data = i_exm_data;
            end else if (i_mwb_en && (i_mwb_addr == i_addr)) begin
                o_data = i_mwb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX register with forwarding, load-use bubble, back-pressure and flush
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int REG_W  = CPU_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [3:0]        id_aluc,
    input  logic [REG_W-1:0]  id_rs_addr,
    input  logic [REG_W-1:0]  id_rt_addr,
    input  logic [REG_W-1:0]  id_wb_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_alu1_sel,
    input  logic              id_alu2_sel,
    input  logic              id_wb_en,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic              exm_wb_en,
    input  logic [REG_W-1:0]  exm_wb_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_wb_en,
    input  logic [REG_W-1:0]  mwb_wb_addr,
    input  logic [DATA_W-1:0] mwb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu1,
    output logic [DATA_W-1:0] alu2,
    output logic [3:0]        ex_aluc,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_wb_addr,
    output logic              ex_wb_en,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              load_use_stall
);

    logic              r_valid;
    logic [3:0]        r_aluc;
    logic [REG_W-1:0]  r_rs_addr;
    logic [REG_W-1:0]  r_rt_addr;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_shamt;
    logic              r_alu1_sel;
    logic              r_alu2_sel;
    logic [REG_W-1:0]  r_wb_addr;
    logic              r_wb_en;
    logic              r_mem_rd;
    logic              r_mem_wr;

    logic              w_adv;
    logic              w_load_in_ex;
    logic              w_rs_dep;
    logic              w_rt_dep;
    logic              w_hazard;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // The register may advance whenever its current content is empty or being accepted
    assign w_adv = !r_valid || ex_ready;

    // A load still in EX cannot supply its data to the instruction being offered in ID
    assign w_load_in_ex = r_valid && r_mem_rd && r_wb_en && (r_wb_addr != '0) && id_valid;
    assign w_rs_dep     = f_uses_rs(id_alu1_sel) && (id_rs_addr == r_wb_addr);
    assign w_rt_dep     = f_uses_rt(id_alu2_sel, id_mem_wr) && (id_rt_addr == r_wb_addr);
    assign w_hazard     = w_load_in_ex && (w_rs_dep || w_rt_dep);

    assign load_use_stall = w_hazard && w_adv && !flush;
    assign id_ready       = w_adv && (flush || !w_hazard);

    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
        .i_addr     (r_rs_addr),
        .i_held     (r_rs_data),
        .i_exm_en   (exm_wb_en),
        .i_exm_addr (exm_wb_addr),
        .i_exm_data (exm_result),
        .i_mwb_en   (mwb_wb_en),
        .i_mwb_addr (mwb_wb_addr),
        .i_mwb_data (mwb_data),
        .o_data     (w_fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
        .i_addr     (r_rt_addr),
        .i_held     (r_rt_data),
        .i_exm_en   (exm_wb_en),
        .i_exm_addr (exm_wb_addr),
        .i_exm_data (exm_result),
        .i_mwb_en   (mwb_wb_en),
        .i_mwb_addr (mwb_wb_addr),
        .i_mwb_data (mwb_data),
        .o_data     (w_fwd_rt)
    );

    // Flush and load-use both insert a bubble; while stalled, operands re-latch their bypassed value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_aluc     <= '0;
            r_rs_addr  <= '0;
            r_rt_addr  <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_shamt    <= '0;
            r_alu1_sel <= 1'b0;
            r_alu2_sel <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_en    <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
        end else if (w_adv) begin
            if (flush || w_hazard) begin
                r_valid  <= 1'b0;
                r_wb_en  <= 1'b0;
                r_mem_rd <= 1'b0;
                r_mem_wr <= 1'b0;
            end else begin
                r_valid    <= id_valid;
                r_aluc     <= id_aluc;
                r_rs_addr  <= id_rs_addr;
                r_rt_addr  <= id_rt_addr;
                r_rs_data  <= id_rs_data;
                r_rt_data  <= id_rt_data;
                r_imm      <= id_imm;
                r_shamt    <= id_shamt;
                r_alu1_sel <= id_alu1_sel;
                r_alu2_sel <= id_alu2_sel;
                r_wb_addr  <= id_wb_addr;
                r_wb_en    <= id_wb_en;
                r_mem_rd   <= id_mem_rd;
                r_mem_wr   <= id_mem_wr;
            end
        end else begin
            r_rs_data <= w_fwd_rs;
            r_rt_data <= w_fwd_rt;
        end
    end

    assign alu1          = (r_alu1_sel == SEL1_SHAMT) ? {{(DATA_W-5){1'b0}}, r_shamt} : w_fwd_rs;
    assign alu2          = (r_alu2_sel == SEL2_IMM) ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign ex_valid      = r_valid;
    assign ex_aluc       = r_aluc;
    assign ex_wb_addr    = r_wb_addr;
    assign ex_wb_en      = r_wb_en;
    assign ex_mem_rd     = r_mem_rd;
    assign ex_mem_wr     = r_mem_wr;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_aluc;
    logic [4:0]  id_rs_addr, id_rt_addr, id_wb_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic        id_alu1_sel, id_alu2_sel;
    logic        id_wb_en, id_mem_rd, id_mem_wr;
    logic        ex_ready, flush;
    logic        exm_wb_en;
    logic [4:0]  exm_wb_addr;
    logic [31:0] exm_result;
    logic        mwb_wb_en;
    logic [4:0]  mwb_wb_addr;
    logic [31:0] mwb_data;
    logic        ex_valid;
    logic [31:0] alu1, alu2, ex_store_data;
    logic [3:0]  ex_aluc;
    logic [4:0]  ex_wb_addr;
    logic        ex_wb_en, ex_mem_rd, ex_mem_wr;
    logic        load_use_stall;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [3:0]  aluc;
        logic [4:0]  rs, rt, wb;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  sh;
        logic        s1, s2, mwr;
        logic [31:0] e1, e2, es;
    } vec_t;

    typedef struct {
        logic [31:0] alu1, alu2, store;
        logic [3:0]  aluc;
        logic [4:0]  wb;
    } exp_t;

    vec_t vt[6];
    exp_t sb[$];
    exp_t e;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_aluc(id_aluc),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_wb_addr(id_wb_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alu1_sel(id_alu1_sel), .id_alu2_sel(id_alu2_sel),
        .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .ex_ready(ex_ready), .flush(flush),
        .exm_wb_en(exm_wb_en), .exm_wb_addr(exm_wb_addr), .exm_result(exm_result),
        .mwb_wb_en(mwb_wb_en), .mwb_wb_addr(mwb_wb_addr), .mwb_data(mwb_data),
        .ex_valid(ex_valid), .alu1(alu1), .alu2(alu2), .ex_aluc(ex_aluc),
        .ex_store_data(ex_store_data), .ex_wb_addr(ex_wb_addr), .ex_wb_en(ex_wb_en),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .load_use_stall(load_use_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 1'b0; id_aluc = '0; id_rs_addr = '0; id_rt_addr = '0; id_wb_addr = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0;
        id_alu1_sel = 1'b0; id_alu2_sel = 1'b0;
        id_wb_en = 1'b0; id_mem_rd = 1'b0; id_mem_wr = 1'b0;
    endtask

    task automatic idle_fwd();
        exm_wb_en = 1'b0; exm_wb_addr = '0; exm_result = '0;
        mwb_wb_en = 1'b0; mwb_wb_addr = '0; mwb_data = '0;
    endtask

    task automatic drive_id(input logic [3:0] aluc, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] wb, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic [4:0] sh, input logic s1,
                            input logic s2, input logic wben, input logic mrd, input logic mwr);
        id_valid = 1'b1; id_aluc = aluc; id_rs_addr = rs; id_rt_addr = rt; id_wb_addr = wb;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
        id_alu1_sel = s1; id_alu2_sel = s2; id_wb_en = wben; id_mem_rd = mrd; id_mem_wr = mwr;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        ex_ready = 1'b1;
        flush = 1'b0;
        idle_id();
        idle_fwd();
        repeat (2) @(posedge clk);
        #1;

        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_wb_en", 32'(ex_wb_en), 32'd0);
        chk("rst_ex_mem_rd", 32'(ex_mem_rd), 32'd0);
        chk("rst_ex_mem_wr", 32'(ex_mem_wr), 32'd0);
        chk("rst_alu1", alu1, 32'd0);
        chk("rst_alu2", alu2, 32'd0);
        chk("rst_store", ex_store_data, 32'd0);
        chk("rst_aluc", 32'(ex_aluc), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_id_ready", 32'(id_ready), 32'd1);

        // back-to-back table, one instruction per cycle, results through the scoreboard
        vt[0] = '{ALUC_ADD, 5'd1, 5'd2, 5'd3,  32'd5,       32'd7,      32'd0,          5'd0,  1'b0, 1'b0, 1'b0, 32'd5,       32'd7,          32'd7};
        vt[1] = '{ALUC_SUB, 5'd4, 5'd5, 5'd6,  32'd100,     32'd30,     32'd0,          5'd0,  1'b0, 1'b0, 1'b0, 32'd100,     32'd30,         32'd30};
        vt[2] = '{ALUC_ADD, 5'd1, 5'd0, 5'd7,  32'h11,      32'd0,      32'hFFFF_FFF0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h11,      32'hFFFF_FFF0,  32'd0};
        vt[3] = '{ALUC_SLL, 5'd0, 5'd9, 5'd10, 32'hDEAD,    32'd3,      32'd0,          5'd31, 1'b1, 1'b0, 1'b0, 32'd31,      32'd3,          32'd3};
        vt[4] = '{ALUC_ADD, 5'd8, 5'd9, 5'd0,  32'h1000,    32'hCAFE,   32'd4,          5'd0,  1'b0, 1'b1, 1'b1, 32'h1000,    32'd4,          32'hCAFE};
        vt[5] = '{ALUC_LUI, 5'd0, 5'd0, 5'd11, 32'd0,       32'd0,      32'h1234_0000,  5'd0,  1'b1, 1'b1, 1'b0, 32'd0,       32'h1234_0000,  32'd0};

        for (int i = 0; i < 6; i++) begin
            drive_id(vt[i].aluc, vt[i].rs, vt[i].rt, vt[i].wb, vt[i].rsd, vt[i].rtd, vt[i].imm,
                     vt[i].sh, vt[i].s1, vt[i].s2, vt[i].wb != 5'd0, 1'b0, vt[i].mwr);
            sb.push_back('{vt[i].e1, vt[i].e2, vt[i].es, vt[i].aluc, vt[i].wb});
            step();
            if (ex_valid && sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("tbl%0d_alu1", i), alu1, e.alu1);
                chk($sformatf("tbl%0d_alu2", i), alu2, e.alu2);
                chk($sformatf("tbl%0d_store", i), ex_store_data, e.store);
                chk($sformatf("tbl%0d_aluc", i), 32'(ex_aluc), 32'(e.aluc));
                chk($sformatf("tbl%0d_wb_addr", i), 32'(ex_wb_addr), 32'(e.wb));
            end else begin
                chk($sformatf("tbl%0d_ex_valid", i), 32'(ex_valid), 32'd1);
            end
        end
        idle_id();
        step();
        chk("tbl_drain_ex_valid", 32'(ex_valid), 32'd0);
        chk("tbl_sb_empty", 32'(sb.size()), 32'd0);

        // forwarding priority: EX/MEM beats MEM/WB
        drive_id(ALUC_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        idle_id();
        exm_wb_en = 1'b1; exm_wb_addr = 5'd1; exm_result = 32'h10;
        mwb_wb_en = 1'b1; mwb_wb_addr = 5'd1; mwb_data = 32'h20;
        #1;
        chk("fwd_exm_wins", alu1, 32'h10);
        chk("fwd_rt_unmatched", ex_store_data, 32'd0);
        exm_wb_en = 1'b0;
        #1;
        chk("fwd_mwb", alu1, 32'h20);
        idle_fwd();

        // writes to $0 are never bypassed
        drive_id(ALUC_OR, 5'd0, 5'd0, 5'd3, 32'h55, 32'h66, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        idle_id();
        exm_wb_en = 1'b1; exm_wb_addr = 5'd0; exm_result = 32'h77;
        mwb_wb_en = 1'b1; mwb_wb_addr = 5'd0; mwb_data = 32'h88;
        #1;
        chk("zero_reg_alu1", alu1, 32'h55);
        chk("zero_reg_store", ex_store_data, 32'h66);
        idle_fwd();

        // load-use: lw $4 then sub using $4
        drive_id(ALUC_ADD, 5'd1, 5'd0, 5'd4, 32'h100, 32'd0, 32'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("lu_load_in_ex", 32'(ex_mem_rd), 32'd1);
        drive_id(ALUC_SUB, 5'd4, 5'd2, 5'd5, 32'd0, 32'd3, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_stall", 32'(load_use_stall), 32'd1);
        chk("lu_id_ready", 32'(id_ready), 32'd0);
        step();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        exm_wb_en = 1'b1; exm_wb_addr = 5'd4; exm_result = 32'h108;
        #1;
        chk("lu_ready_after_bubble", 32'(id_ready), 32'd1);
        chk("lu_stall_cleared", 32'(load_use_stall), 32'd0);
        step();
        idle_id();
        idle_fwd();
        mwb_wb_en = 1'b1; mwb_wb_addr = 5'd4; mwb_data = 32'h99;
        #1;
        chk("lu_sub_valid", 32'(ex_valid), 32'd1);
        chk("lu_sub_aluc", 32'(ex_aluc), 32'(ALUC_SUB));
        chk("lu_alu1_from_mwb", alu1, 32'h99);
        chk("lu_alu2", alu2, 32'd3);
        idle_fwd();

        // back-pressure: rt dependency survives the source retiring
        drive_id(ALUC_ADD, 5'd1, 5'd2, 5'd6, 32'd5, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        idle_id();
        ex_ready = 1'b0;
        mwb_wb_en = 1'b1; mwb_wb_addr = 5'd2; mwb_data = 32'hAB;
        #1;
        chk("bp_alu2_fwd", alu2, 32'hAB);
        chk("bp_id_ready", 32'(id_ready), 32'd0);
        step();
        mwb_wb_en = 1'b0; mwb_data = 32'd0;
        #1;
        chk("bp_alu2_relatched", alu2, 32'hAB);
        step();
        step();
        chk("bp_held_valid", 32'(ex_valid), 32'd1);
        chk("bp_store_held", ex_store_data, 32'hAB);
        ex_ready = 1'b1;
        #1;
        chk("bp_alu2_release", alu2, 32'hAB);
        chk("bp_alu1", alu1, 32'd5);
        step();
        chk("bp_drained", 32'(ex_valid), 32'd0);

        // flush together with a load-use hazard: flush wins
        drive_id(ALUC_ADD, 5'd1, 5'd0, 5'd7, 32'h200, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        drive_id(ALUC_XOR, 5'd7, 5'd3, 5'd8, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_id_ready", 32'(id_ready), 32'd1);
        chk("fl_no_stall", 32'(load_use_stall), 32'd0);
        step();
        chk("fl_ex_valid", 32'(ex_valid), 32'd0);
        chk("fl_ex_wb_en", 32'(ex_wb_en), 32'd0);
        chk("fl_ex_mem_rd", 32'(ex_mem_rd), 32'd0);
        flush = 1'b0;
        idle_id();

        // asynchronous reset while stalled
        drive_id(ALUC_AND, 5'd1, 5'd2, 5'd8, 32'h1234, 32'h5678, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        idle_id();
        ex_ready = 1'b0;
        step();
        chk("rs_pre_valid", 32'(ex_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_ex_valid", 32'(ex_valid), 32'd0);
        chk("rs_alu1", alu1, 32'd0);
        chk("rs_alu2", alu2, 32'd0);
        chk("rs_store", ex_store_data, 32'd0);
        chk("rs_aluc", 32'(ex_aluc), 32'd0);
        chk("rs_wb_en", 32'(ex_wb_en), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ex_ready = 1'b1;
        step();
        chk("rs_id_ready_after", 32'(id_ready), 32'd1);
        chk("rs_ex_valid_after", 32'(ex_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
